// File: rtl/axi4_lite_bridge_csr_pkg.sv
// Shared definitions for the bridge CSR block: register offsets, AXI response
// codes, FSM state types and CONTROL/ERROR bit positions.
package uart_axi4_csr_pkg;

    localparam logic [11:0] ADDR_VERSION  = 12'h000;
    localparam logic [11:0] ADDR_CONTROL  = 12'h004;
    localparam logic [11:0] ADDR_STATUS   = 12'h008;
    localparam logic [11:0] ADDR_ERROR    = 12'h00C;
    localparam logic [11:0] ADDR_TX_COUNT = 12'h010;
    localparam logic [11:0] ADDR_RX_COUNT = 12'h014;
    localparam logic [11:0] ADDR_SCRATCH  = 12'h018;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int CTRL_ENABLE_BIT     = 0;
    localparam int CTRL_STAT_RESET_BIT = 1;
    localparam int ERR_CLEAR_BIT       = 16;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_WAIT_W  = 2'd1,
        W_WAIT_AW = 2'd2,
        W_RESP    = 2'd3
    } write_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } read_state_t;

    typedef enum logic [2:0] {
        REG_VERSION  = 3'd0,
        REG_CONTROL  = 3'd1,
        REG_STATUS   = 3'd2,
        REG_ERROR    = 3'd3,
        REG_TX_COUNT = 3'd4,
        REG_RX_COUNT = 3'd5,
        REG_SCRATCH  = 3'd6,
        REG_NONE     = 3'd7
    } reg_idx_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// 32-bit AXI4-Lite bus bundle with master and slave views.
interface axi4_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_csr_decode.sv
// Combinational address decoder: maps a bus address to a register index and
// the AXI response that an access to it should return.
module axi4_lite_csr_decode
    import uart_axi4_csr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic [31:0] addr_i,
    output reg_idx_t    hit_o,
    output logic [1:0]  resp_o
);

    // Misalignment outranks window/offset decoding.
    always_comb begin
        hit_o  = REG_NONE;
        resp_o = RESP_DECERR;
        if (addr_i[1:0] != 2'b00) begin
            resp_o = RESP_SLVERR;
        end else if (addr_i[31:12] != BASE_ADDR[31:12]) begin
            resp_o = RESP_DECERR;
        end else begin
            resp_o = RESP_OKAY;
            case (addr_i[11:0])
                ADDR_VERSION:  hit_o = REG_VERSION;
                ADDR_CONTROL:  hit_o = REG_CONTROL;
                ADDR_STATUS:   hit_o = REG_STATUS;
                ADDR_ERROR:    hit_o = REG_ERROR;
                ADDR_TX_COUNT: hit_o = REG_TX_COUNT;
                ADDR_RX_COUNT: hit_o = REG_RX_COUNT;
                ADDR_SCRATCH:  hit_o = REG_SCRATCH;
                default: begin
                    hit_o  = REG_NONE;
                    resp_o = RESP_DECERR;
                end
            endcase
        end
    end

endmodule

// File: rtl/axi4_lite_bridge_csr.sv
// AXI4-Lite register block exposing UART-AXI bridge status, control and
// scratch registers. Read and write channels run independently.
module axi4_lite_bridge_csr
    import uart_axi4_csr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_1000,
    parameter logic [31:0] VERSION       = 32'h0001_0000,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    axi4_lite_if.slave  axi,
    input  logic        bridge_busy,
    input  logic [7:0]  bridge_error_code,
    input  logic [15:0] tx_transaction_count,
    input  logic [15:0] rx_transaction_count,
    input  logic [7:0]  fifo_status_flags,
    output logic        reset_statistics,
    output logic        bridge_enable
);

    write_state_t w_state_q;
    logic         awready_q;
    logic         wready_q;
    logic         bvalid_q;
    logic [1:0]   bresp_q;
    logic [31:0]  awaddr_q;
    logic [31:0]  wdata_q;
    logic [3:0]   wstrb_q;

    read_state_t  r_state_q;
    logic         arready_q;
    logic         rvalid_q;
    logic [31:0]  rdata_q;
    logic [1:0]   rresp_q;

    logic         enable_q;
    logic         stat_reset_q;
    logic [31:0]  scratch_q;
    logic [7:0]   err_cap_q;
    logic         err_sticky_q;
    logic [7:0]   err_prev_q;

    logic         aw_hs_s;
    logic         w_hs_s;
    logic         ar_hs_s;
    logic         commit_s;
    logic [31:0]  wr_addr_s;
    logic [31:0]  wr_data_s;
    logic [3:0]   wr_strb_s;
    reg_idx_t     wr_hit_s;
    logic [1:0]   wr_resp_s;
    reg_idx_t     rd_hit_s;
    logic [1:0]   rd_resp_s;
    logic [31:0]  rd_data_s;
    logic         wr_ok_s;
    logic         ctrl_wr_s;
    logic         err_clear_s;
    logic         err_new_s;

    assign aw_hs_s = axi.awvalid & awready_q;
    assign w_hs_s  = axi.wvalid & wready_q;
    assign ar_hs_s = axi.arvalid & arready_q;

    // Select live or latched address/data so the commit sees the complete write.
    always_comb begin
        wr_addr_s = axi.awaddr;
        wr_data_s = axi.wdata;
        wr_strb_s = axi.wstrb;
        commit_s  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                commit_s = aw_hs_s & w_hs_s;
            end
            W_WAIT_W: begin
                wr_addr_s = awaddr_q;
                commit_s  = w_hs_s;
            end
            W_WAIT_AW: begin
                wr_data_s = wdata_q;
                wr_strb_s = wstrb_q;
                commit_s  = aw_hs_s;
            end
            default: begin
                commit_s = 1'b0;
            end
        endcase
    end

    axi4_lite_csr_decode #(.BASE_ADDR(BASE_ADDR)) u_wr_decode (
        .addr_i (wr_addr_s),
        .hit_o  (wr_hit_s),
        .resp_o (wr_resp_s)
    );

    axi4_lite_csr_decode #(.BASE_ADDR(BASE_ADDR)) u_rd_decode (
        .addr_i (axi.araddr),
        .hit_o  (rd_hit_s),
        .resp_o (rd_resp_s)
    );

    assign wr_ok_s     = commit_s && (wr_resp_s == RESP_OKAY);
    assign ctrl_wr_s   = wr_ok_s && (wr_hit_s == REG_CONTROL) && wr_strb_s[0];
    assign err_clear_s = wr_ok_s && (wr_hit_s == REG_ERROR) && wr_strb_s[2]
                         && wr_data_s[ERR_CLEAR_BIT];
    // A code counts as a new error only on the edge it changes to a nonzero value.
    assign err_new_s   = (bridge_error_code != 8'h00) && (bridge_error_code != err_prev_q);

    // Register read mux.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (rd_hit_s)
            REG_VERSION:  rd_data_s = VERSION;
            REG_CONTROL:  rd_data_s = {31'h0, enable_q};
            REG_STATUS:   rd_data_s = {23'h0, bridge_busy, fifo_status_flags};
            REG_ERROR:    rd_data_s = {15'h0, err_sticky_q, err_cap_q, bridge_error_code};
            REG_TX_COUNT: rd_data_s = {16'h0, tx_transaction_count};
            REG_RX_COUNT: rd_data_s = {16'h0, rx_transaction_count};
            REG_SCRATCH:  rd_data_s = scratch_q;
            default:      rd_data_s = 32'h0000_0000;
        endcase
    end

    // Write channel FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awaddr_q  <= 32'h0000_0000;
            wdata_q   <= 32'h0000_0000;
            wstrb_q   <= 4'h0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs_s && w_hs_s) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_resp_s;
                        w_state_q <= W_RESP;
                    end else if (aw_hs_s) begin
                        awaddr_q  <= axi.awaddr;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_WAIT_W;
                    end else if (w_hs_s) begin
                        wdata_q   <= axi.wdata;
                        wstrb_q   <= axi.wstrb;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b0;
                        w_state_q <= W_WAIT_AW;
                    end else begin
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                W_WAIT_W: begin
                    if (w_hs_s) begin
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_resp_s;
                        w_state_q <= W_RESP;
                    end
                end
                W_WAIT_AW: begin
                    if (aw_hs_s) begin
                        awready_q <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_resp_s;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (axi.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: begin
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b0;
                    w_state_q <= W_IDLE;
                end
            endcase
        end
    end

    // Read channel FSM; data and response are frozen until rready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0000_0000;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        rdata_q   <= (rd_resp_s == RESP_OKAY) ? rd_data_s : 32'h0000_0000;
                        rresp_q   <= rd_resp_s;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state_q <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (axi.rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: begin
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b0;
                    r_state_q <= R_IDLE;
                end
            endcase
        end
    end

    // Control, scratch and sticky error state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q     <= 1'b0;
            stat_reset_q <= 1'b0;
            scratch_q    <= SCRATCH_RESET;
            err_cap_q    <= 8'h00;
            err_sticky_q <= 1'b0;
            err_prev_q   <= 8'h00;
        end else begin
            stat_reset_q <= ctrl_wr_s && wr_data_s[CTRL_STAT_RESET_BIT];
            err_prev_q   <= bridge_error_code;
            if (ctrl_wr_s) begin
                enable_q <= wr_data_s[CTRL_ENABLE_BIT];
            end
            if (wr_ok_s && (wr_hit_s == REG_SCRATCH)) begin
                scratch_q <= apply_wstrb(scratch_q, wr_data_s, wr_strb_s);
            end
            // Capture beats a simultaneous clear so a fresh error is never lost.
            if ((!err_sticky_q || err_clear_s) && err_new_s) begin
                err_cap_q    <= bridge_error_code;
                err_sticky_q <= 1'b1;
            end else if (err_clear_s) begin
                err_cap_q    <= 8'h00;
                err_sticky_q <= 1'b0;
            end
        end
    end

    assign axi.awready      = awready_q;
    assign axi.wready       = wready_q;
    assign axi.bvalid       = bvalid_q;
    assign axi.bresp        = bresp_q;
    assign axi.arready      = arready_q;
    assign axi.rvalid       = rvalid_q;
    assign axi.rdata        = rdata_q;
    assign axi.rresp        = rresp_q;
    assign reset_statistics = stat_reset_q;
    assign bridge_enable    = enable_q;

endmodule

// File: tb/tb_axi4_lite_bridge_csr.sv
// Directed plus randomized bench for axi4_lite_bridge_csr against a register-map
// reference model kept in plain variables.
module tb_axi4_lite_bridge_csr;

    logic        clk;
    logic        rst_n;
    logic        bridge_busy;
    logic [7:0]  bridge_error_code;
    logic [15:0] tx_transaction_count;
    logic [15:0] rx_transaction_count;
    logic [7:0]  fifo_status_flags;
    logic        reset_statistics;
    logic        bridge_enable;

    axi4_lite_if bus ();

    axi4_lite_bridge_csr dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .axi                  (bus),
        .bridge_busy          (bridge_busy),
        .bridge_error_code    (bridge_error_code),
        .tx_transaction_count (tx_transaction_count),
        .rx_transaction_count (rx_transaction_count),
        .fifo_status_flags    (fifo_status_flags),
        .reset_statistics     (reset_statistics),
        .bridge_enable        (bridge_enable)
    );

    int vectors;
    int miscompares;
    int pulse_cnt;

    logic [31:0] m_scratch;
    logic        m_enable;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (reset_statistics === 1'b1) pulse_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        if (a % 32'd4 != 32'd0) return 2'b10;
        if (a < 32'h0000_1000 || a >= 32'h0000_2000) return 2'b11;
        if (a - 32'h0000_1000 > 32'h18) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        logic [31:0] off;
        if (exp_resp(a) != 2'b00) return 32'h0;
        off = a - 32'h0000_1000;
        case (off)
            32'h00: return 32'h0001_0000;
            32'h04: return {31'h0, m_enable};
            32'h08: return {23'h0, bridge_busy, fifo_status_flags};
            32'h0C: return {24'h0, bridge_error_code};
            32'h10: return {16'h0, tx_transaction_count};
            32'h14: return {16'h0, rx_transaction_count};
            32'h18: return m_scratch;
            default: return 32'h0;
        endcase
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int code_on_commit, output logic [1:0] resp);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_hit;
        bit w_hit;
        int c = 0;
        resp = 2'bxx;
        while (!(aw_done && w_done) && c < 50) begin
            @(negedge clk);
            bus.awaddr  = addr;
            bus.wdata   = data;
            bus.wstrb   = strb;
            bus.awvalid = !aw_done && (c >= aw_dly);
            bus.wvalid  = !w_done && (c >= w_dly);
            aw_hit = bus.awvalid && (bus.awready === 1'b1);
            w_hit  = bus.wvalid && (bus.wready === 1'b1);
            if (code_on_commit >= 0 && (aw_done || aw_hit) && (w_done || w_hit))
                bridge_error_code = 8'(code_on_commit);
            @(posedge clk);
            if (aw_hit) aw_done = 1'b1;
            if (w_hit)  w_done  = 1'b1;
            c++;
        end
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        c = 0;
        while (bus.bvalid !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("write_bvalid_seen", {31'h0, bus.bvalid}, 32'h1);
        resp = bus.bresp;
        @(posedge clk);
        @(negedge clk);
        check("write_bvalid_single", {31'h0, bus.bvalid}, 32'h0);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int c = 0;
        @(negedge clk);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        while (bus.arready !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("read_rvalid_before", {31'h0, bus.rvalid}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0;
        check("read_rvalid_after_hs", {31'h0, bus.rvalid}, 32'h1);
        data = bus.rdata;
        resp = bus.rresp;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        logic [1:0]  ws;
        logic [31:0] pool [10];
        int          p0;

        vectors = 0; miscompares = 0; pulse_cnt = 0;
        m_scratch = 32'h0; m_enable = 1'b0;
        rst_n = 1'b0;
        bus.awaddr = 32'h0; bus.awvalid = 1'b0; bus.wdata = 32'h0; bus.wstrb = 4'h0;
        bus.wvalid = 1'b0; bus.bready = 1'b1; bus.araddr = 32'h0; bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        bridge_busy = 1'b0; bridge_error_code = 8'h00; tx_transaction_count = 16'h0;
        rx_transaction_count = 16'h0; fifo_status_flags = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", {31'h0, bus.awready}, 32'h0);
        check("rst_arready", {31'h0, bus.arready}, 32'h0);
        check("rst_bvalid", {31'h0, bus.bvalid}, 32'h0);
        check("rst_rvalid", {31'h0, bus.rvalid}, 32'h0);
        check("rst_enable", {31'h0, bridge_enable}, 32'h0);
        check("rst_stat", {31'h0, reset_statistics}, 32'h0);
        rst_n = 1'b1;

        // 1: VERSION
        axi_read(32'h1000, rd, rs);
        check("version_data", rd, 32'h0001_0000);
        check("version_resp", {30'h0, rs}, 32'h0);

        // 2: W three cycles ahead of AW, byte-strobed scratch
        p0 = pulse_cnt;
        axi_write(32'h1018, 32'hDEADBEEF, 4'b0101, 3, 0, -1, ws);
        check("scratch_wr_resp", {30'h0, ws}, 32'h0);
        m_scratch = 32'h00AD00EF;
        axi_read(32'h1018, rd, rs);
        check("scratch_rd", rd, 32'h00AD00EF);
        check("scratch_no_pulse", pulse_cnt - p0, 32'd0);

        // 3: CONTROL enable + stat_reset pulse, back-to-back pulses
        p0 = pulse_cnt;
        axi_write(32'h1004, 32'h3, 4'hF, 0, 0, -1, ws);
        check("ctrl_resp", {30'h0, ws}, 32'h0);
        check("ctrl_enable", {31'h0, bridge_enable}, 32'h1);
        check("ctrl_pulse_once", pulse_cnt - p0, 32'd1);
        m_enable = 1'b1;
        axi_read(32'h1004, rd, rs);
        check("ctrl_rd", rd, 32'h1);
        p0 = pulse_cnt;
        axi_write(32'h1004, 32'h3, 4'h1, 0, 2, -1, ws);
        axi_write(32'h1004, 32'h3, 4'h1, 1, 0, -1, ws);
        check("ctrl_pulse_b2b", pulse_cnt - p0, 32'd2);

        // 5: decode errors and RO writes
        axi_read(32'h1002, rd, rs);
        check("misalign_rresp", {30'h0, rs}, 32'h2);
        axi_read(32'h101C, rd, rs);
        check("unmapped_rresp", {30'h0, rs}, 32'h3);
        axi_write(32'h2000, 32'hFFFF_FFFF, 4'hF, 0, 0, -1, ws);
        check("outwin_bresp", {30'h0, ws}, 32'h3);
        axi_read(32'h1018, rd, rs);
        check("outwin_unchanged", rd, m_scratch);
        bridge_busy = 1'b1; fifo_status_flags = 8'hA5;
        axi_write(32'h1008, 32'h0, 4'hF, 0, 0, -1, ws);
        check("ro_bresp", {30'h0, ws}, 32'h0);
        axi_read(32'h1008, rd, rs);
        check("status_rd", rd, 32'h0000_01A5);

        // Randomized traffic against the register model
        pool = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010,
                 32'h1014, 32'h1018, 32'h101C, 32'h1005, 32'h3018};
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic [3:0]  s;
            int          exp_p;
            a = pool[$urandom_range(0, 9)];
            bridge_busy = 1'($urandom);
            fifo_status_flags = 8'($urandom);
            tx_transaction_count = 16'($urandom);
            rx_transaction_count = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                exp_p = 0;
                p0 = pulse_cnt;
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), -1, ws);
                check("rand_bresp", {30'h0, ws}, {30'h0, exp_resp(a)});
                if (exp_resp(a) == 2'b00 && a == 32'h1018) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) m_scratch[b*8 +: 8] = d[b*8 +: 8];
                end
                if (exp_resp(a) == 2'b00 && a == 32'h1004 && s[0]) begin
                    m_enable = d[0];
                    exp_p = d[1] ? 1 : 0;
                end
                check("rand_pulses", pulse_cnt - p0, exp_p);
                check("rand_enable", {31'h0, bridge_enable}, {31'h0, m_enable});
            end else begin
                axi_read(a, rd, rs);
                check("rand_rresp", {30'h0, rs}, {30'h0, exp_resp(a)});
                check("rand_rdata", rd, exp_read(a));
            end
        end

        // 4: sticky error capture, clear, and clear-vs-capture race
        @(negedge clk); bridge_error_code = 8'h02;
        repeat (2) @(negedge clk); bridge_error_code = 8'h05;
        repeat (2) @(negedge clk);
        axi_read(32'h100C, rd, rs);
        check("err_first", rd, 32'h0001_0205);
        axi_write(32'h100C, 32'h0001_0000, 4'b0100, 0, 0, -1, ws);
        axi_read(32'h100C, rd, rs);
        check("err_cleared", rd, 32'h0000_0005);
        axi_write(32'h100C, 32'h0001_0000, 4'b0100, 0, 0, 7, ws);
        axi_read(32'h100C, rd, rs);
        check("err_race", rd, 32'h0001_0707);

        // 6: reset while a write response is stalled
        axi_write(32'h1004, 32'h1, 4'h1, 0, 0, -1, ws);
        m_enable = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        bus.awaddr = 32'h1018; bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        repeat (10) @(negedge clk);
        check("stall_bvalid", {31'h0, bus.bvalid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_bvalid", {31'h0, bus.bvalid}, 32'h0);
        check("midrst_enable", {31'h0, bridge_enable}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.bready = 1'b1;
        m_scratch = 32'h0; m_enable = 1'b0;
        repeat (2) @(negedge clk);
        check("postrst_no_bvalid", {31'h0, bus.bvalid}, 32'h0);
        axi_read(32'h1018, rd, rs);
        check("postrst_scratch", rd, 32'h0);
        axi_write(32'h1018, 32'hCAFE_F00D, 4'hF, 0, 0, -1, ws);
        check("postrst_bresp", {30'h0, ws}, 32'h0);
        axi_read(32'h1018, rd, rs);
        check("postrst_rd", rd, 32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi4_lite_bridge_csr.md
Name: axi4_lite_bridge_csr

Overview:
AXI4-Lite slave register block that sits directly downstream of the UART-AXI4 bridge master. It is the first target the bridge addresses on the AXI bus. It exposes the bridge's status monitoring signals (busy, error code, transaction counters, FIFO flags) as memory-mapped registers, and provides control and scratch registers. The host can therefore inspect and control the bridge over the same UART link.

Parameters:
BASE_ADDR, 32'h0000_1000, base of the 4 KiB register window (must be 4 KiB aligned)
VERSION, 32'h0001_0000, constant returned by the VERSION register
SCRATCH_RESET, 32'h0000_0000, reset value of the SCRATCH register

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
axi  modport  axi4_lite_if.slave  AXI4-Lite slave port (32-bit addr/data, 4-bit wstrb)
bridge_busy  input  1  live busy flag from bridge
bridge_error_code  input  8  live error code from bridge (0 = no error)
tx_transaction_count  input  16  bridge write-transaction counter
rx_transaction_count  input  16  bridge read-transaction counter
fifo_status_flags  input  8  bridge FIFO flags
reset_statistics  output  1  one-cycle pulse to clear the bridge counters
bridge_enable  output  1  level output, CONTROL[0]

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0, all state is cleared:
  - awready, wready, bvalid, arready, rvalid = 0; bresp, rresp, rdata = 0
  - reset_statistics = 0; bridge_enable = 0; SCRATCH = SCRATCH_RESET; ERROR sticky fields = 0
  - Both FSMs return to IDLE
- Reset mid-transaction: any pending response is dropped. There is no deferred response after reset release.
- Register map (offsets from BASE_ADDR):
  - 0x000 VERSION, RO
  - 0x004 CONTROL, RW. [0] enable, RW. [1] stat_reset, write-1-pulse, always reads 0. Other bits read 0.
  - 0x008 STATUS, RO. {23'b0, bridge_busy, fifo_status_flags}
  - 0x00C ERROR. [7:0] live bridge_error_code, RO. [15:8] first nonzero code captured since last clear. [16] sticky_valid. Writing wdata[16]=1 with wstrb[2]=1 clears [16:8].
  - 0x010 TX_COUNT, RO. {16'b0, tx_transaction_count}
  - 0x014 RX_COUNT, RO. {16'b0, rx_transaction_count}
  - 0x018 SCRATCH, RW, byte-strobed
- Decode rules:
  - addr[1:0] != 0 -> SLVERR (2'b10), no state change
  - Address outside the window, or unmapped offset -> DECERR (2'b11)
  - Writes to RO registers -> OKAY, ignored
  - wstrb applies per byte to RW fields; wstrb=0 is a legal no-op write
- Write FSM: W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP.
  - W_IDLE: awready=wready=1.
    - AW and W handshake in the same cycle -> W_RESP
    - AW only -> W_WAIT_W (awaddr latched)
    - W only -> W_WAIT_AW (wdata/wstrb latched)
  - W_WAIT_W: wready=1, awready=0. W_WAIT_AW: awready=1, wready=0.
  - The register update commits on the clock edge entering W_RESP.
  - W_RESP: bvalid=1, bresp per decode. Hold until bready, then W_IDLE. awready=wready=0 throughout.
- Read FSM: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On AR handshake, rdata/rresp are registered -> R_DATA. rvalid rises one cycle after the handshake.
  - R_DATA: rvalid=1. rdata and rresp are held stable until rready, then R_IDLE. Minimum two cycles per read.
- The read and write channels are fully independent.
  - A read sampled on the same edge as a write commit returns the pre-write value.
- stat_reset: reset_statistics pulses high for exactly one cycle, the cycle after commit. Back-to-back writes give one pulse per write.
- Error capture:
  - When sticky_valid=0 and bridge_error_code!=0, [15:8] captures the code and [16] sets on that edge.
  - Later codes are ignored until cleared.
  - If a clear and a new nonzero code occur on the same edge, capture wins: the new code is stored and [16]=1.
- Counter inputs are sampled as-is. Wrap-around is the bridge's concern.

Decomposition:
- Shared package uart_axi4_csr_pkg:
  - register offset localparams (ADDR_VERSION…ADDR_SCRATCH)
  - AXI resp constants (RESP_OKAY, RESP_SLVERR, RESP_DECERR)
  - write_state_t and read_state_t enums
  - CONTROL bit index constants
- One sub-module is natural: axi4_lite_csr_decode, a combinational address→{hit index, resp} decoder shared by both channels. Everything else stays in the top module.

Test Plan:
1. After reset release, read 0x1000 -> rdata=32'h0001_0000, rresp=OKAY, rvalid exactly 1 cycle after the AR handshake.
2. W presented 3 cycles before AW: write 0x1018 data 32'hDEADBEEF, wstrb=4'b0101 over SCRATCH=0 -> single bvalid OKAY; readback = 32'h00AD00EF.
3. Write 0x1004 with 32'h3 -> bridge_enable=1; reset_statistics high for exactly 1 cycle; readback = 32'h1.
4. Drive bridge_error_code 8'h02 then 8'h05 -> ERROR reads 32'h0001_0205. Write 32'h0001_0000 wstrb 4'b0100 -> reads 32'h0000_0005. Clear on the same edge as code 8'h07 appears -> reads 32'h0001_0707.
5. Read 0x1002 -> SLVERR. Read 0x101C -> DECERR. Write 0x2000 -> bresp DECERR with registers unchanged. Write to STATUS -> OKAY, value unchanged.
6. Hold bready=0 for 10 cycles, then assert rst_n=0 mid-response -> bvalid drops immediately, and after release the next write completes normally.
